// File: rtl/match_irq_controller_if.sv
// rtl/match_irq_controller_if.sv - requester, compare-unit and processor port bus bundle
interface match_irq_controller_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data_1;
    logic [NUM_REQ*DATA_W-1:0] req_data_2;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         cmp_data_1;
    logic [DATA_W-1:0]         cmp_data_2;
    logic                      cmp_strobe;
    logic                      cmp_match;
    logic [7:0]                port_id;
    logic                      read_strobe;
    logic                      write_strobe;
    logic [7:0]                out_port;
    logic [7:0]                in_port;
    logic                      interrupt;

    // Controller side
    modport slave (
        input  req, req_data_1, req_data_2, cmp_match,
        input  port_id, read_strobe, write_strobe, out_port,
        output gnt, cmp_data_1, cmp_data_2, cmp_strobe, in_port, interrupt
    );

    // Requesters, compare unit and processor side
    modport master (
        output req, req_data_1, req_data_2, cmp_match,
        output port_id, read_strobe, write_strobe, out_port,
        input  gnt, cmp_data_1, cmp_data_2, cmp_strobe, in_port, interrupt
    );
endinterface

// File: rtl/match_irq_controller.sv
// rtl/match_irq_controller.sv - round-robin shared compare unit with sticky match interrupt
module match_irq_controller #(
    parameter int         NUM_REQ     = 4,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] PORT_STATUS = 8'h10,
    parameter logic [7:0] PORT_LAST   = 8'h11,
    parameter logic [7:0] PORT_MASK   = 8'h12,
    parameter logic [7:0] PORT_CLEAR  = 8'h13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    match_irq_controller_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_rr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_strobe;
    logic [DATA_W-1:0]   r_d1;
    logic [DATA_W-1:0]   r_d2;
    logic [7:0]          r_last;
    logic [NUM_REQ-1:0]  r_pending;
    logic [NUM_REQ-1:0]  r_mask;
    logic [7:0]          r_in_port;
    logic                r_irq;

    logic                w_found;
    logic [IDX_W-1:0]    w_sel;
    logic                w_hi_found;
    logic [IDX_W-1:0]    w_hi_sel;
    logic                w_lo_found;
    logic [IDX_W-1:0]    w_lo_sel;
    logic [DATA_W-1:0]   w_op1;
    logic [DATA_W-1:0]   w_op2;
    logic [IDX_W-1:0]    w_rr_next;
    logic [NUM_REQ-1:0]  w_set;
    logic [NUM_REQ-1:0]  w_clr;
    logic                w_wr_mask;
    logic [7:0]          w_rd_data;
    logic                w_unused_ok;

    // read_strobe and the upper write-data bits carry no meaning here
    assign w_unused_ok = ^{bus.read_strobe, bus.out_port};

    // Round-robin pick: lowest set request at/after the pointer, else lowest set overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_found = 1'b0;
        w_lo_sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_lo_found = 1'b1;
                w_lo_sel   = IDX_W'(i);
                if (IDX_W'(i) >= r_rr) begin
                    w_hi_found = 1'b1;
                    w_hi_sel   = IDX_W'(i);
                end
            end
        end
        w_found = w_lo_found;
        w_sel   = w_hi_found ? w_hi_sel : w_lo_sel;
    end

    // Operand mux for the selected requester
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_op1 = bus.req_data_1[i*DATA_W +: DATA_W];
                w_op2 = bus.req_data_2[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_rr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

    // Issue/capture sequencer; the compare unit registers its result at the ISSUE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_rr     <= '0;
            r_gnt    <= '0;
            r_strobe <= 1'b0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_last   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gnt    <= '0;
                    r_strobe <= 1'b0;
                    if (w_found) begin
                        r_idx    <= w_sel;
                        r_d1     <= w_op1;
                        r_d2     <= w_op2;
                        r_gnt    <= NUM_REQ'(1) << w_sel;
                        r_strobe <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_gnt    <= '0;
                    r_strobe <= 1'b0;
                    r_rr     <= w_rr_next;
                    r_state  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_last  <= {1'b1, bus.cmp_match, 3'b000, 3'(r_idx)};
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt    <= '0;
                    r_strobe <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign w_set     = (r_state == S_CAPTURE && bus.cmp_match) ? (NUM_REQ'(1) << r_idx) : '0;
    assign w_clr     = (bus.write_strobe && bus.port_id == PORT_CLEAR) ? bus.out_port[NUM_REQ-1:0] : '0;
    assign w_wr_mask = bus.write_strobe && (bus.port_id == PORT_MASK);

    // Sticky pending flags (a set beats a same-cycle clear) and the interrupt mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_wr_mask) begin
                r_mask <= bus.out_port[NUM_REQ-1:0];
            end
        end
    end

    // Read-data mux, unused upper bits read as zero
    always_comb begin
        w_rd_data = 8'h00;
        if (bus.port_id == PORT_STATUS) begin
            w_rd_data[NUM_REQ-1:0] = r_pending;
        end else if (bus.port_id == PORT_LAST) begin
            w_rd_data = r_last;
        end else if (bus.port_id == PORT_MASK) begin
            w_rd_data[NUM_REQ-1:0] = r_mask;
        end
    end

    // Registered read port and level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_port <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_in_port <= w_rd_data;
            r_irq     <= |(r_pending & r_mask);
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.cmp_strobe = r_strobe;
    assign bus.cmp_data_1 = r_d1;
    assign bus.cmp_data_2 = r_d2;
    assign bus.in_port    = r_in_port;
    assign bus.interrupt  = r_irq;
endmodule

// File: tb/tb_match_irq_controller.sv
// tb/tb_match_irq_controller.sv - scoreboard bench for match_irq_controller
module tb_match_irq_controller;
    localparam logic [7:0] P_STATUS = 8'h10;
    localparam logic [7:0] P_LAST   = 8'h11;
    localparam logic [7:0] P_MASK   = 8'h12;
    localparam logic [7:0] P_CLEAR  = 8'h13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    match_irq_controller_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    match_irq_controller #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] d1;
        logic [7:0] d2;
        int         gap;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;

    // Compare unit model: registered equality, captured on read_strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.cmp_match <= 1'b0;
        else if (bus.cmp_strobe) bus.cmp_match <= (bus.cmp_data_1 == bus.cmp_data_2);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every grant/strobe cycle pops one expected issue
    always @(negedge clk) begin
        if (rst_n && (bus.gnt != 4'b0 || bus.cmp_strobe)) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: got gnt=%b strobe=%b expected none", bus.gnt, bus.cmp_strobe);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_gnt", {28'd0, bus.gnt}, {28'd0, e.gnt});
                chk("sb_strobe", {31'd0, bus.cmp_strobe}, 32'd1);
                chk("sb_d1", {24'd0, bus.cmp_data_1}, {24'd0, e.d1});
                chk("sb_d2", {24'd0, bus.cmp_data_2}, {24'd0, e.d2});
                if (e.gap != 0) chk("sb_gap", cyc - last_gnt_cyc, e.gap);
            end
            last_gnt_cyc = cyc;
        end
    end

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.port_id = addr;
        bus.out_port = data;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        @(negedge clk);
        bus.port_id = addr;
        @(negedge clk);
        chk(name, {24'd0, bus.in_port}, {24'd0, exp});
    endtask

    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b, input int gap);
        exp_t e;
        e.gnt = 4'b0001 << idx;
        e.d1 = a;
        e.d2 = b;
        e.gap = gap;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_data_1[idx*8 +: 8] = a;
        bus.req_data_2[idx*8 +: 8] = b;
        bus.req[idx] = 1'b1;
    endtask

    // Returns at the negedge of the ISSUE cycle with the granted request dropped
    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (bus.gnt == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.gnt == 4'b0) begin
            n_total++;
            $display("FAIL %s_timeout: got no grant expected grant within 20 cycles", name);
        end
        bus.req = bus.req & ~bus.gnt;
    endtask

    initial begin
        int ng;
        logic [7:0] addrs [6];
        addrs = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'hFF};
        bus.req = '0;
        bus.req_data_1 = '0;
        bus.req_data_2 = '0;
        bus.port_id = 8'h00;
        bus.read_strobe = 1'b0;
        bus.write_strobe = 1'b0;
        bus.out_port = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("rst_strobe", {31'd0, bus.cmp_strobe}, 32'd0);
        chk("rst_d1", {24'd0, bus.cmp_data_1}, 32'd0);
        chk("rst_irq", {31'd0, bus.interrupt}, 32'd0);
        rst_n = 1'b1;
        foreach (addrs[i]) rd(addrs[i], 8'h00, "rst_rd");

        // Matching compare on requester 2; operand change after grant is ignored
        wr(P_MASK, 8'h0F);
        rd(P_MASK, 8'h0F, "mask_rd");
        issue(2, 8'hA5, 8'hA5, 0);
        wait_gnt("t2");
        bus.req_data_1[2*8 +: 8] = 8'h00;
        @(negedge clk);
        chk("cap_hold_d1", {24'd0, bus.cmp_data_1}, 32'hA5);
        @(negedge clk);
        chk("irq_pre", {31'd0, bus.interrupt}, 32'd0);
        @(negedge clk);
        chk("irq_post", {31'd0, bus.interrupt}, 32'd1);
        rd(P_STATUS, 8'h04, "t2_status");
        rd(P_LAST, 8'hC2, "t2_last");

        // Non-matching compare on requester 1
        wr(P_CLEAR, 8'h04);
        @(negedge clk);
        chk("irq_clr", {31'd0, bus.interrupt}, 32'd0);
        issue(1, 8'h3C, 8'h3D, 0);
        wait_gnt("t3");
        repeat (4) @(negedge clk);
        chk("t3_irq", {31'd0, bus.interrupt}, 32'd0);
        rd(P_STATUS, 8'h00, "t3_status");
        rd(P_LAST, 8'h81, "t3_last");

        // Requester 3 moves the pointer back to 0
        issue(3, 8'h00, 8'hFF, 0);
        wait_gnt("t3b");
        repeat (3) @(negedge clk);
        rd(P_LAST, 8'h83, "t3b_last");

        // All four requesting: 0,1,2,3,0 at 3-cycle spacing; 0 and 2 match
        bus.req_data_1 = {8'h33, 8'h22, 8'h11, 8'h00};
        bus.req_data_2 = {8'h30, 8'h22, 8'h10, 8'h00};
        sb_q.push_back('{4'b0001, 8'h00, 8'h00, 0});
        sb_q.push_back('{4'b0010, 8'h11, 8'h10, 3});
        sb_q.push_back('{4'b0100, 8'h22, 8'h22, 3});
        sb_q.push_back('{4'b1000, 8'h33, 8'h30, 3});
        sb_q.push_back('{4'b0001, 8'h00, 8'h00, 3});
        @(negedge clk);
        bus.req = 4'b1111;
        ng = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0) begin
                ng++;
                if (ng == 5) bus.req = 4'b0;
            end
        end
        chk("t4_grants", ng, 5);
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
        rd(P_STATUS, 8'h05, "t4_status");
        rd(P_LAST, 8'hC0, "t4_last");
        chk("t4_irq", {31'd0, bus.interrupt}, 32'd1);

        // Clear of bit 0 collides with a CAPTURE setting bit 0: set wins
        issue(0, 8'h5A, 8'h5A, 0);
        wait_gnt("t5");
        @(negedge clk);
        bus.port_id = P_CLEAR;
        bus.out_port = 8'h01;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        rd(P_STATUS, 8'h05, "t5_collide");
        wr(P_CLEAR, 8'h05);
        chk("irq_hold", {31'd0, bus.interrupt}, 32'd1);
        @(negedge clk);
        chk("irq_fall", {31'd0, bus.interrupt}, 32'd0);
        rd(P_STATUS, 8'h00, "t5_status");

        // Reset during CAPTURE of a matching compare
        issue(1, 8'h77, 8'h77, 0);
        wait_gnt("t6");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_strobe", {31'd0, bus.cmp_strobe}, 32'd0);
        chk("t6_d1", {24'd0, bus.cmp_data_1}, 32'd0);
        chk("t6_in_port", {24'd0, bus.in_port}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(P_STATUS, 8'h00, "t6_status");
        rd(P_LAST, 8'h00, "t6_last");
        rd(P_MASK, 8'h00, "t6_mask");
        chk("t6_irq", {31'd0, bus.interrupt}, 32'd0);

        // Pointer restarted at 0: requesters 1 and 3 -> 1 wins
        bus.req_data_1 = {8'h99, 8'h00, 8'h12, 8'h00};
        bus.req_data_2 = {8'h99, 8'h00, 8'h34, 8'h00};
        sb_q.push_back('{4'b0010, 8'h12, 8'h34, 0});
        @(negedge clk);
        bus.req = 4'b1010;
        wait_gnt("t6b");
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
        rd(P_LAST, 8'h81, "t6b_last");

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/match_irq_controller.md
Name: match_irq_controller

Overview:
- Shares one external 8-bit equality-compare unit among NUM_REQ requesters, arbitrated round-robin.
- Sequences each compare as an issue/capture pair: drives the operands and a one-cycle strobe into the unit's read_strobe input, then samples its registered match output one cycle later.
- Collects match results into sticky pending flags.
- Exposes pending flags, mask and last-result to the soft processor over its port bus and raises a level interrupt.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
DATA_W, 8, operand width
PORT_STATUS, 8'h10, read address: pending flags
PORT_LAST, 8'h11, read address: last-result register
PORT_MASK, 8'h12, read/write address: interrupt mask
PORT_CLEAR, 8'h13, write address: write-1-to-clear pending

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester compare request, held until granted
req_data_1  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
req_data_2  in  NUM_REQ*DATA_W  operand B, same packing
gnt  out  NUM_REQ  one-hot, one-cycle pulse when request accepted
cmp_data_1  out  DATA_W  operand A to compare unit
cmp_data_2  out  DATA_W  operand B to compare unit
cmp_strobe  out  1  drives compare unit read_strobe
cmp_match  in  1  compare unit registered match output
port_id  in  8  processor port address
read_strobe  in  1  processor read qualifier
write_strobe  in  1  processor write qualifier
out_port  in  8  processor write data
in_port  out  8  processor read data (registered)
interrupt  out  1  level interrupt to processor

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt=0, cmp_strobe=0, cmp_data_1/2=0.
  - pending=0, mask=0, last=0, rr pointer=0, in_port=0, interrupt=0.
  - Reset mid-compare aborts it: no pending update, no last update.
- FSM states IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any req bit is set, choose the first set bit at or after the rr pointer, wrapping at NUM_REQ.
  - Latch that requester's operands into cmp_data_1/2 and its index into idx.
  - Pulse gnt[idx] and drive cmp_strobe=1 for the ISSUE cycle; go to ISSUE.
- ISSUE (1 cycle):
  - cmp_strobe=1; operands stable.
  - rr pointer := (idx+1) mod NUM_REQ; go to CAPTURE.
- CAPTURE (1 cycle):
  - cmp_strobe=0; operands held.
  - At the closing edge sample cmp_match; this is the unit's output registered at the ISSUE edge.
  - If match, pending[idx] := 1.
  - last := {valid=1 at bit7, match at bit6, zeros, idx at [2:0]}.
  - Go to IDLE.
- Throughput: one compare per 3 cycles; req-to-result latency is 3 cycles.
- gnt pulses in the ISSUE cycle. The requester must drop or update req in the cycle after gnt; a req still high in IDLE is a new request.
- Requests arriving during ISSUE/CAPTURE wait and are not lost, as long as req is held.
- Operand changes after grant have no effect; operands are latched.
- Port writes take effect on the clk edge where write_strobe=1 and port_id matches:
  - PORT_MASK: mask := out_port[NUM_REQ-1:0].
  - PORT_CLEAR: pending &= ~out_port[NUM_REQ-1:0].
  - If a CAPTURE set and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Port reads: in_port is registered from port_id every cycle, independent of read_strobe:
  - PORT_STATUS: pending, zero-extended.
  - PORT_LAST: last.
  - PORT_MASK: mask, zero-extended.
  - Any other address: 8'h00.
- Reading has no side effects.
- interrupt is registered: interrupt := |(pending & mask), so it asserts 1 cycle after the pending or mask update and stays high until cleared or masked.
- Unused upper bits (NUM_REQ<8) read 0; writes to them are ignored.

Test Plan:
- Reset with req=0 -> all outputs 0, in_port=0 for every port_id, cmp_strobe never asserts.
- mask=8'h0F; req[2]=1 with operands 8'hA5/8'hA5; compare model returns match -> gnt=4'b0100 pulse, cmp_strobe high exactly 1 cycle, pending=8'h04, last=8'hC2, interrupt high 1 cycle later.
- req[1]=1 with operands 8'h3C/8'h3D -> pending unchanged, last=8'h81, interrupt stays 0.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0 at 3-cycle spacing; no requester granted twice before all others are granted.
- pending=8'h05, write PORT_CLEAR=8'h01 in the same cycle a CAPTURE sets bit 0 -> pending=8'h05; next write 8'h05 -> pending=0 and interrupt falls 1 cycle later.
- Assert rst_n low during CAPTURE of a matching compare -> pending=0, last=0, cmp_strobe=0 immediately; after release the FSM restarts in IDLE with rr pointer 0.
